// File: rtl/pe_link_endpoint.sv
// Processing-element side endpoint for the router proc port: builds and sends routing
// flits over a 4-phase req/ack link, and receives/buffers one flit per handshake.
module pe_link_endpoint #(
    parameter int n     = 36,
    parameter bit srcx  = 1'b0,
    parameter bit srcy  = 1'b0,
    parameter int cnt_w = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic             tx_dest_x,
    input  logic             tx_dest_y,
    input  logic [n-5:0]     tx_payload,
    output logic             tx_req_o,
    input  logic             tx_ack_i,
    output logic [n-1:0]     tx_data_o,
    input  logic             rx_req_i,
    output logic             rx_ack_o,
    input  logic [n-1:0]     rx_data_i,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic [n-1:0]     rx_data,
    output logic             rx_misroute,
    output logic [cnt_w-1:0] tx_count,
    output logic [cnt_w-1:0] rx_count
);

    typedef enum logic [1:0] {T_IDLE, T_SETUP, T_REQ, T_REL} tx_state_t;
    typedef enum logic       {R_IDLE, R_ACK} rx_state_t;

    localparam logic [cnt_w-1:0] CNT_ONE = {{(cnt_w-1){1'b0}}, 1'b1};

    tx_state_t        tx_state_q;
    rx_state_t        rx_state_q;
    logic             ack_s1_q, ack_s_q, req_s1_q, req_s_q;
    logic             tx_ready_q, tx_req_q, rx_ack_q, rx_valid_q, rx_misroute_q;
    logic [n-1:0]     tx_data_q, rx_data_q;
    logic [cnt_w-1:0] tx_count_q, rx_count_q;
    logic [n-1:0]     tx_flit_d;

    // Direction bits compare against our own coordinate so the router can pick a port
    // without doing the comparison itself.
    assign tx_flit_d = {tx_dest_x, tx_dest_y, tx_dest_x & ~srcx, tx_dest_y & ~srcy, tx_payload};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_s1_q <= 1'b0;
            ack_s_q  <= 1'b0;
            req_s1_q <= 1'b0;
            req_s_q  <= 1'b0;
        end else begin
            ack_s1_q <= tx_ack_i;
            ack_s_q  <= ack_s1_q;
            req_s1_q <= rx_req_i;
            req_s_q  <= req_s1_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= T_IDLE;
            tx_ready_q <= 1'b1;
            tx_req_q   <= 1'b0;
            tx_data_q  <= '0;
            tx_count_q <= '0;
        end else begin
            case (tx_state_q)
                T_IDLE: begin
                    if (tx_valid) begin
                        tx_data_q  <= tx_flit_d;
                        tx_ready_q <= 1'b0;
                        tx_state_q <= T_SETUP;
                    end
                end
                T_SETUP: begin
                    tx_req_q   <= 1'b1;
                    tx_state_q <= T_REQ;
                end
                T_REQ: begin
                    if (ack_s_q) begin
                        tx_req_q   <= 1'b0;
                        tx_state_q <= T_REL;
                    end
                end
                T_REL: begin
                    if (!ack_s_q) begin
                        tx_count_q <= tx_count_q + CNT_ONE;
                        tx_ready_q <= 1'b1;
                        tx_state_q <= T_IDLE;
                    end
                end
                default: begin
                    tx_req_q   <= 1'b0;
                    tx_ready_q <= 1'b1;
                    tx_state_q <= T_IDLE;
                end
            endcase
        end
    end

    // Capture only from an empty buffer; a consume and a capture never share a cycle,
    // and the router holds req until we ack, which is our backpressure.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_q    <= R_IDLE;
            rx_ack_q      <= 1'b0;
            rx_valid_q    <= 1'b0;
            rx_data_q     <= '0;
            rx_misroute_q <= 1'b0;
            rx_count_q    <= '0;
        end else begin
            if (rx_valid_q && rx_ready)
                rx_valid_q <= 1'b0;
            case (rx_state_q)
                R_IDLE: begin
                    if (req_s_q && !rx_valid_q) begin
                        rx_data_q  <= rx_data_i;
                        rx_valid_q <= 1'b1;
                        rx_ack_q   <= 1'b1;
                        rx_state_q <= R_ACK;
                        if (rx_data_i[n-1] != srcx || rx_data_i[n-2] != srcy)
                            rx_misroute_q <= 1'b1;
                    end
                end
                R_ACK: begin
                    if (!req_s_q) begin
                        rx_ack_q   <= 1'b0;
                        rx_count_q <= rx_count_q + CNT_ONE;
                        rx_state_q <= R_IDLE;
                    end
                end
                default: begin
                    rx_ack_q   <= 1'b0;
                    rx_state_q <= R_IDLE;
                end
            endcase
        end
    end

    assign tx_ready    = tx_ready_q;
    assign tx_req_o    = tx_req_q;
    assign tx_data_o   = tx_data_q;
    assign tx_count    = tx_count_q;
    assign rx_ack_o    = rx_ack_q;
    assign rx_valid    = rx_valid_q;
    assign rx_data     = rx_data_q;
    assign rx_misroute = rx_misroute_q;
    assign rx_count    = rx_count_q;

endmodule

// File: tb/tb_pe_link_endpoint.sv
// Directed bench for pe_link_endpoint: the bench plays both the PE and the router sides.
module tb_pe_link_endpoint;
    localparam int N = 36;

    logic          clk = 1'b0;
    logic          rst;
    logic          tx_valid, tx_ready, tx_dest_x, tx_dest_y;
    logic [N-5:0]  tx_payload;
    logic          tx_req_o, tx_ack_i;
    logic [N-1:0]  tx_data_o;
    logic          rx_req_i, rx_ack_o;
    logic [N-1:0]  rx_data_i;
    logic          rx_valid, rx_ready;
    logic [N-1:0]  rx_data;
    logic          rx_misroute;
    logic [15:0]   tx_count, rx_count;

    int n_cmp = 0;
    int n_err = 0;

    pe_link_endpoint #(.n(N), .srcx(1'b0), .srcy(1'b0), .cnt_w(16)) dut (
        .clk(clk), .rst(rst),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_dest_x(tx_dest_x), .tx_dest_y(tx_dest_y),
        .tx_payload(tx_payload), .tx_req_o(tx_req_o), .tx_ack_i(tx_ack_i), .tx_data_o(tx_data_o),
        .rx_req_i(rx_req_i), .rx_ack_o(rx_ack_o), .rx_data_i(rx_data_i),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .rx_misroute(rx_misroute), .tx_count(tx_count), .rx_count(rx_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tx_req(input logic val, output int cyc);
        cyc = 0;
        while (tx_req_o !== val && cyc < 40) begin tick(); cyc++; end
    endtask

    task automatic wait_tx_ready(output int cyc);
        cyc = 0;
        while (tx_ready !== 1'b1 && cyc < 40) begin tick(); cyc++; end
    endtask

    task automatic wait_rx_ack(input logic val, output int cyc);
        cyc = 0;
        while (rx_ack_o !== val && cyc < 40) begin tick(); cyc++; end
    endtask

    // Router side of one TX handshake, starting right after the flit was accepted.
    task automatic tx_handshake(input string tag, input int ack_delay, input logic [N-1:0] exp);
        int   cyc;
        logic stable;
        stable = 1'b1;
        wait_tx_req(1'b1, cyc);
        n_cmp++;
        if (cyc !== 1) begin n_err++; $display("FAIL %s_req_rise: cycles=%0d expected=1", tag, cyc); end
        repeat (ack_delay) begin
            tick();
            if (tx_req_o !== 1'b1 || tx_ready !== 1'b0 || tx_data_o !== exp) stable = 1'b0;
        end
        tx_ack_i = 1'b1;
        wait_tx_req(1'b0, cyc);
        n_cmp++;
        if (cyc !== 3) begin n_err++; $display("FAIL %s_ack_sync: cycles=%0d expected=3", tag, cyc); end
        if (tx_data_o !== exp || tx_ready !== 1'b0) stable = 1'b0;
        tx_ack_i = 1'b0;
        wait_tx_ready(cyc);
        n_cmp++;
        if (cyc !== 3) begin n_err++; $display("FAIL %s_rel_sync: cycles=%0d expected=3", tag, cyc); end
        n_cmp++;
        if (stable !== 1'b1) begin n_err++; $display("FAIL %s_hold: req/ready/data not held got=0 expected=1", tag); end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        tx_valid = 1'b0; tx_dest_x = 1'b0; tx_dest_y = 1'b0; tx_payload = '0;
        tx_ack_i = 1'b0; rx_req_i = 1'b0; rx_data_i = '0; rx_ready = 1'b0;
        #12;
        n_cmp++;
        if ({tx_req_o, rx_ack_o, rx_valid, rx_misroute} !== 4'b0000) begin
            n_err++; $display("FAIL reset_flags: got=%b expected=0000", {tx_req_o, rx_ack_o, rx_valid, rx_misroute});
        end
        n_cmp++;
        if (tx_data_o !== '0 || rx_data !== '0) begin
            n_err++; $display("FAIL reset_data: tx=%h rx=%h expected 0", tx_data_o, rx_data);
        end
        n_cmp++;
        if (tx_count !== 16'd0 || rx_count !== 16'd0) begin
            n_err++; $display("FAIL reset_counts: tx=%0d rx=%0d expected 0", tx_count, rx_count);
        end
        n_cmp++;
        if (tx_ready !== 1'b1) begin n_err++; $display("FAIL reset_tx_ready: got=%b expected=1", tx_ready); end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_tx_single;
        tx_dest_x = 1'b1; tx_dest_y = 1'b1; tx_payload = 32'hFFFF_FFFF; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        n_cmp++;
        if (tx_data_o !== 36'hF_FFFF_FFFF) begin n_err++; $display("FAIL tx1_flit: got=%h expected=FFFFFFFFF", tx_data_o); end
        n_cmp++;
        if (tx_ready !== 1'b0 || tx_req_o !== 1'b0) begin
            n_err++; $display("FAIL tx1_setup: ready=%b req=%b expected 0 0", tx_ready, tx_req_o);
        end
        tx_handshake("tx1", 3, 36'hF_FFFF_FFFF);
        n_cmp++;
        if (tx_count !== 16'd1) begin n_err++; $display("FAIL tx1_count: got=%0d expected=1", tx_count); end
    endtask

    task automatic test_back_to_back;
        tx_dest_x = 1'b1; tx_dest_y = 1'b0; tx_payload = 32'hEEEE_EEEE; tx_valid = 1'b1;
        tick();
        n_cmp++;
        if (tx_data_o !== 36'hA_EEEE_EEEE) begin n_err++; $display("FAIL tx2_flit: got=%h expected=AEEEEEEEE", tx_data_o); end
        tx_handshake("tx2a", 2, 36'hA_EEEE_EEEE);
        tick();
        n_cmp++;
        if (tx_ready !== 1'b0) begin n_err++; $display("FAIL tx2_reaccept: ready=%b expected=0", tx_ready); end
        tx_valid = 1'b0;
        tx_handshake("tx2b", 0, 36'hA_EEEE_EEEE);
        repeat (5) tick();
        n_cmp++;
        if (tx_count !== 16'd3 || tx_ready !== 1'b1 || tx_req_o !== 1'b0) begin
            n_err++; $display("FAIL tx2_total: count=%0d ready=%b req=%b expected 3 1 0", tx_count, tx_ready, tx_req_o);
        end
    endtask

    task automatic test_rx_single;
        int cyc;
        rx_ready = 1'b1; rx_data_i = 36'h0_DDDD_DDDD; rx_req_i = 1'b1;
        wait_rx_ack(1'b1, cyc);
        n_cmp++;
        if (cyc !== 3) begin n_err++; $display("FAIL rx1_ack_rise: cycles=%0d expected=3", cyc); end
        n_cmp++;
        if (rx_valid !== 1'b1 || rx_data !== 36'h0_DDDD_DDDD) begin
            n_err++; $display("FAIL rx1_capture: valid=%b data=%h expected 1 0DDDDDDDD", rx_valid, rx_data);
        end
        tick();
        n_cmp++;
        if (rx_valid !== 1'b0) begin n_err++; $display("FAIL rx1_consume: valid=%b expected=0", rx_valid); end
        rx_req_i = 1'b0;
        wait_rx_ack(1'b0, cyc);
        n_cmp++;
        if (cyc !== 3) begin n_err++; $display("FAIL rx1_ack_fall: cycles=%0d expected=3", cyc); end
        n_cmp++;
        if (rx_count !== 16'd1 || rx_misroute !== 1'b0) begin
            n_err++; $display("FAIL rx1_count: count=%0d misroute=%b expected 1 0", rx_count, rx_misroute);
        end
        rx_ready = 1'b0;
    endtask

    task automatic test_rx_backpressure;
        int cyc;
        rx_data_i = 36'h0_1111_1111; rx_req_i = 1'b1;
        wait_rx_ack(1'b1, cyc);
        rx_req_i = 1'b0;
        wait_rx_ack(1'b0, cyc);
        n_cmp++;
        if (rx_valid !== 1'b1 || rx_data !== 36'h0_1111_1111) begin
            n_err++; $display("FAIL rxbp_first: valid=%b data=%h expected 1 011111111", rx_valid, rx_data);
        end
        rx_data_i = 36'h0_2222_2222; rx_req_i = 1'b1;
        repeat (8) tick();
        n_cmp++;
        if (rx_ack_o !== 1'b0 || rx_data !== 36'h0_1111_1111 || rx_valid !== 1'b1) begin
            n_err++; $display("FAIL rxbp_hold: ack=%b data=%h valid=%b expected 0 011111111 1", rx_ack_o, rx_data, rx_valid);
        end
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        n_cmp++;
        if (rx_valid !== 1'b0 || rx_ack_o !== 1'b0) begin
            n_err++; $display("FAIL rxbp_no_refill: valid=%b ack=%b expected 0 0", rx_valid, rx_ack_o);
        end
        wait_rx_ack(1'b1, cyc);
        n_cmp++;
        if (cyc !== 1 || rx_data !== 36'h0_2222_2222) begin
            n_err++; $display("FAIL rxbp_second: cycles=%0d data=%h expected 1 022222222", cyc, rx_data);
        end
        rx_req_i = 1'b0;
        wait_rx_ack(1'b0, cyc);
        n_cmp++;
        if (rx_count !== 16'd3) begin n_err++; $display("FAIL rxbp_count: got=%0d expected=3", rx_count); end
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic test_misroute;
        int cyc;
        rx_data_i = 36'hC_CCCC_CCCC; rx_req_i = 1'b1;
        wait_rx_ack(1'b1, cyc);
        n_cmp++;
        if (rx_data !== 36'hC_CCCC_CCCC || rx_misroute !== 1'b1) begin
            n_err++; $display("FAIL mis_flag: data=%h misroute=%b expected CCCCCCCCC 1", rx_data, rx_misroute);
        end
        rx_req_i = 1'b0;
        wait_rx_ack(1'b0, cyc);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        rx_data_i = 36'h0_1234_5678; rx_req_i = 1'b1;
        wait_rx_ack(1'b1, cyc);
        n_cmp++;
        if (rx_data !== 36'h0_1234_5678 || rx_misroute !== 1'b1) begin
            n_err++; $display("FAIL mis_sticky: data=%h misroute=%b expected 012345678 1", rx_data, rx_misroute);
        end
        rx_req_i = 1'b0;
        wait_rx_ack(1'b0, cyc);
        n_cmp++;
        if (rx_count !== 16'd5) begin n_err++; $display("FAIL mis_count: got=%0d expected=5", rx_count); end
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic test_simultaneous_reset;
        int cyc;
        tx_dest_x = 1'b0; tx_dest_y = 1'b1; tx_payload = 32'h0BAD_F00D; tx_valid = 1'b1;
        rx_data_i = 36'h0_CAFE_F00D; rx_req_i = 1'b1;
        tick();
        tx_valid = 1'b0;
        wait_rx_ack(1'b1, cyc);
        n_cmp++;
        if (tx_req_o !== 1'b1 || tx_data_o !== 36'h5_0BAD_F00D || rx_valid !== 1'b1 || tx_count !== 16'd3) begin
            n_err++; $display("FAIL sim_active: req=%b txd=%h rxv=%b txc=%0d expected 1 50BADF00D 1 3",
                              tx_req_o, tx_data_o, rx_valid, tx_count);
        end
        #3;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({tx_req_o, rx_ack_o, rx_valid, rx_misroute} !== 4'b0000) begin
            n_err++; $display("FAIL rst_async_flags: got=%b expected=0000", {tx_req_o, rx_ack_o, rx_valid, rx_misroute});
        end
        n_cmp++;
        if (tx_count !== 16'd0 || rx_count !== 16'd0 || tx_data_o !== '0 || rx_data !== '0) begin
            n_err++; $display("FAIL rst_async_state: txc=%0d rxc=%0d txd=%h rxd=%h expected all 0",
                              tx_count, rx_count, tx_data_o, rx_data);
        end
        rx_req_i = 1'b0;
        #2;
        rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (tx_ready !== 1'b1 || tx_req_o !== 1'b0 || rx_ack_o !== 1'b0) begin
            n_err++; $display("FAIL rst_recover: ready=%b req=%b ack=%b expected 1 0 0", tx_ready, tx_req_o, rx_ack_o);
        end
    endtask

    initial begin
        test_reset();
        test_tx_single();
        test_back_to_back();
        test_rx_single();
        test_rx_backpressure();
        test_misroute();
        test_simultaneous_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
